// File: rtl/proc_pkg.sv
// proc_pkg: state, opcode-class and select encodings shared by the sequencer
package proc_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_RDREG, S_EXEC, S_MEMRD, S_MEMLAT, S_MEMWR, S_WB, S_RETIRE, S_HALT
    } state_t;
    localparam logic [1:0] CLS_ALU = 2'b00, CLS_LDST = 2'b01, CLS_BR = 2'b10, CLS_MOV = 2'b11;
    localparam logic [1:0] LS_LDI = 2'b00, LS_LDD = 2'b01, LS_LDX = 2'b10, LS_ST = 2'b11;
    localparam logic [3:0] BR_JMP = 4'h8, BR_CALL = 4'h9, BR_RET = 4'hA, BR_HALT = 4'hF;
    localparam logic [1:0] WB_ALU = 2'd0, WB_IMM = 2'd1, WB_REGA = 2'd2, WB_MEM = 2'd3;
    localparam logic [3:0] FSL_CMP = 4'hF;
    // unknown flag bits must never read as set
    function automatic logic [3:0] known_set(input logic [3:0] f);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (f[i] === 1'b1);
        return r;
    endfunction
endpackage

// File: rtl/proc_ctrl_seq_if.sv
// proc_ctrl_seq_if: controller <-> datapath instruction, strobe and status bundle
interface proc_ctrl_seq_if #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 8,
    parameter int DADDR_W = 7
);
    logic [15:0]        instr;
    logic [PC_W-1:0]    pc_cur;
    logic [3:0]         alu_sreg;
    logic [DATA_W-1:0]  reg_a_data, reg_b_data;
    logic               pc_hold, pc_jump;
    logic [PC_W-1:0]    pc_target;
    logic               rd_en, wr_en;
    logic [2:0]         reg_a, reg_b, reg_c;
    logic [1:0]         wb_sel;
    logic [7:0]         imm;
    logic [3:0]         alu_fsl;
    logic               mem_rd, mem_wr;
    logic [DADDR_W-1:0] mem_addr;
    logic               mem_wsel;
    logic [3:0]         sreg;
    logic               halted;
    logic [1:0]         fault;
    modport master (
        input  instr, pc_cur, alu_sreg, reg_a_data, reg_b_data,
        output pc_hold, pc_jump, pc_target, rd_en, wr_en, reg_a, reg_b, reg_c, wb_sel, imm,
               alu_fsl, mem_rd, mem_wr, mem_addr, mem_wsel, sreg, halted, fault
    );
    modport slave (
        output instr, pc_cur, alu_sreg, reg_a_data, reg_b_data,
        input  pc_hold, pc_jump, pc_target, rd_en, wr_en, reg_a, reg_b, reg_c, wb_sel, imm,
               alu_fsl, mem_rd, mem_wr, mem_addr, mem_wsel, sreg, halted, fault
    );
endinterface

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] ptr_q, prev;
    logic [PW:0]   cnt_q;
    assign prev    = ptr_q - PW'(1);
    assign top_o   = mem_q[prev];
    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push_i) begin
            mem_q[ptr_q] <= data_i;
            ptr_q        <= ptr_q + PW'(1);
            if (!full_o) cnt_q <= cnt_q + (PW+1)'(1);
        end else if (pop_i && !empty_o) begin
            ptr_q <= prev;
            cnt_q <= cnt_q - (PW+1)'(1);
        end
    end
endmodule

// File: rtl/proc_ctrl_seq.sv
// proc_ctrl_seq: multi-cycle fetch/decode/execute sequencer driving PC, GPR, ALU and data memory
module proc_ctrl_seq
    import proc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PC_W      = 8,
    parameter int DADDR_W   = 7,
    parameter int RAS_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    proc_ctrl_seq_if.master bus
);
    state_t             state_q, state_d;
    logic [15:0]        ir_q, ir_d;
    logic               jump_q, jump_d;
    logic [PC_W-1:0]    target_q, target_d;
    logic [DADDR_W-1:0] addr_q, addr_d;
    logic [3:0]         sreg_q, sreg_d;
    logic [1:0]         fault_q, fault_d;
    logic [PC_W-1:0]    ras_top;
    logic               ras_full, ras_empty;
    logic [1:0]         f_cls, i_cls, i_ls;
    logic [3:0]         f_sub, i_sub;
    logic               fetch, is_call, is_ret, taken;
    logic               alu, ldi, ldd, ldx, st;
    logic               unused_ok;

    assign f_cls   = bus.instr[15:14];
    assign f_sub   = bus.instr[13:10];
    assign i_cls   = ir_q[15:14];
    assign i_ls    = ir_q[13:12];
    assign i_sub   = ir_q[13:10];
    assign fetch   = state_q == S_FETCH;
    assign is_call = fetch && f_cls == CLS_BR && f_sub == BR_CALL;
    assign is_ret  = fetch && f_cls == CLS_BR && f_sub == BR_RET;
    // sub-codes 0..7: bit pair picks the flag, LSB inverts the sense
    assign taken   = !f_sub[3] ? sreg_q[f_sub[2:1]] ^ f_sub[0]
                   : f_sub == BR_JMP || f_sub == BR_CALL || (f_sub == BR_RET && !ras_empty);

    ras_stack #(.DEPTH(RAS_DEPTH), .W(PC_W)) u_ras (
        .clk     (clk),
        .rst     (rst),
        .push_i  (is_call),
        .pop_i   (is_ret && !ras_empty),
        .data_i  (bus.pc_cur + PC_W'(1)),
        .top_o   (ras_top),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        jump_d   = jump_q;
        target_d = target_q;
        addr_d   = addr_q;
        sreg_d   = sreg_q;
        fault_d  = fault_q;
        case (state_q)
            S_FETCH: begin
                ir_d     = bus.instr;
                jump_d   = f_cls == CLS_BR && taken;
                target_d = is_ret ? ras_top : PC_W'(bus.instr[9:2]);
                addr_d   = f_cls == CLS_MOV ? DADDR_W'(bus.instr[13:7]) : DADDR_W'(bus.instr[9:3]);
                fault_d  = fault_q | {is_ret && ras_empty, is_call && ras_full};
                state_d  = f_cls == CLS_MOV ? S_MEMRD
                         : f_cls == CLS_BR ? (f_sub == BR_HALT ? S_HALT : S_RETIRE)
                         : (f_cls == CLS_LDST && bus.instr[13:12] == LS_LDI) ? S_WB : S_RDREG;
            end
            S_RDREG: begin
                addr_d  = ldx ? DADDR_W'(bus.reg_b_data) : addr_q;
                state_d = alu ? S_EXEC : ldd ? S_WB : ldx ? S_MEMRD : S_MEMWR;
            end
            S_EXEC:   state_d = S_WB;
            S_MEMRD:  state_d = S_MEMLAT;
            S_MEMLAT: begin
                addr_d  = i_cls == CLS_MOV ? DADDR_W'(ir_q[6:0]) : addr_q;
                state_d = i_cls == CLS_MOV ? S_MEMWR : S_WB;
            end
            S_MEMWR:  state_d = S_RETIRE;
            S_WB: begin
                sreg_d  = alu ? known_set(bus.alu_sreg) : sreg_q;
                state_d = S_RETIRE;
            end
            S_RETIRE: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            ir_q     <= '0;
            jump_q   <= 1'b0;
            target_q <= '0;
            addr_q   <= '0;
            sreg_q   <= '0;
            fault_q  <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            jump_q   <= jump_d;
            target_q <= target_d;
            addr_q   <= addr_d;
            sreg_q   <= sreg_d;
            fault_q  <= fault_d;
        end
    end

    assign alu = i_cls == CLS_ALU;
    assign ldi = i_cls == CLS_LDST && i_ls == LS_LDI;
    assign ldd = i_cls == CLS_LDST && i_ls == LS_LDD;
    assign ldx = i_cls == CLS_LDST && i_ls == LS_LDX;
    assign st  = i_cls == CLS_LDST && i_ls == LS_ST;

    assign bus.pc_hold   = !(state_q == S_RETIRE && !jump_q);
    assign bus.pc_jump   = state_q == S_RETIRE && jump_q;
    assign bus.pc_target = target_q;
    assign bus.rd_en     = state_q == S_RDREG;
    assign bus.wr_en     = state_q == S_WB && !(alu && i_sub == FSL_CMP);
    assign bus.mem_rd    = state_q == S_MEMRD;
    assign bus.mem_wr    = state_q == S_MEMWR;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wsel  = i_cls == CLS_MOV;
    assign bus.sreg      = sreg_q;
    assign bus.fault     = fault_q;
    assign bus.halted    = state_q == S_HALT;
    assign bus.reg_a     = alu ? ir_q[9:7] : ldd ? ir_q[6:4] : st ? ir_q[2:0] : 3'd0;
    assign bus.reg_b     = alu ? ir_q[6:4] : ldx ? ir_q[9:7] : 3'd0;
    assign bus.reg_c     = alu ? ir_q[3:1] : ldi ? ir_q[2:0] : ldd ? ir_q[9:7] : ldx ? ir_q[6:4] : 3'd0;
    assign bus.wb_sel    = ldi ? WB_IMM : ldd ? WB_REGA : ldx ? WB_MEM : WB_ALU;
    assign bus.imm       = ldi ? ir_q[10:3] : 8'd0;
    assign bus.alu_fsl   = alu ? i_sub : 4'd0;
    assign unused_ok     = ^{bus.reg_a_data, bus.reg_b_data};
endmodule

// File: tb/tb_proc_ctrl_seq.sv
// tb_proc_ctrl_seq: random instruction stream checked against a per-instruction behavioural model
module tb_proc_ctrl_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic [3:0] sreg_m;
    logic [1:0] fault_m;
    logic [7:0] pc_m;
    logic [7:0] ras_m[$];

    always #5 clk = ~clk;

    proc_ctrl_seq_if #(.DATA_W(8), .PC_W(8), .DADDR_W(7)) bus ();
    proc_ctrl_seq #(.DATA_W(8), .PC_W(8), .DADDR_W(7), .RAS_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] strb();
        return {bus.pc_hold, bus.pc_jump, bus.rd_en, bus.wr_en, bus.mem_rd, bus.mem_wr};
    endfunction

    task automatic check_idle();
        check("idle_strobes", 32'(strb()), 32'h20);
        check("idle_sreg", 32'(bus.sreg), 32'd0);
        check("idle_fault", 32'(bus.fault), 32'd0);
        check("idle_halted", 32'(bus.halted), 32'd0);
        check("idle_reg_c", 32'(bus.reg_c), 32'd0);
        check("idle_wb_sel", 32'(bus.wb_sel), 32'd0);
        check("idle_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("idle_pc_target", 32'(bus.pc_target), 32'd0);
        check("idle_alu_fsl", 32'(bus.alu_fsl), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle();
        @(posedge clk);
        #1 rst = 1'b0;
        sreg_m  = 4'd0;
        fault_m = 2'd0;
        ras_m.delete();
    endtask

    // one instruction from FETCH through RETIRE; entered and left just after a rising edge
    task automatic run_instr(input logic [15:0] ins, input logic [7:0] rb, input logic [3:0] sr);
        logic [1:0] cls, ls, ewb;
        logic [3:0] sub;
        logic [2:0] ea, eb, ec;
        logic [7:0] eimm, tgt;
        logic [6:0] ma_rd, ma_wr;
        logic       taken, cmp;
        string      path;
        cls = ins[15:14]; ls = ins[13:12]; sub = ins[13:10];
        cmp = cls == 2'd0 && sub == 4'hF;
        ea = 3'd0; eb = 3'd0; ec = 3'd0; ewb = 2'd0; eimm = 8'd0;
        taken = 1'b0; tgt = ins[9:2];
        ma_rd = cls == 2'd3 ? ins[13:7] : rb[6:0];
        ma_wr = cls == 2'd3 ? ins[6:0] : ins[9:3];
        case (cls)
            2'd0: begin path = "FREWT"; ea = ins[9:7]; eb = ins[6:4]; ec = ins[3:1]; sreg_m = sr; end
            2'd1: case (ls)
                2'd0: begin path = "FWT"; eimm = ins[10:3]; ec = ins[2:0]; ewb = 2'd1; end
                2'd1: begin path = "FRWT"; ec = ins[9:7]; ea = ins[6:4]; ewb = 2'd2; end
                2'd2: begin path = "FRMLWT"; eb = ins[9:7]; ec = ins[6:4]; ewb = 2'd3; end
                default: begin path = "FRST"; ea = ins[2:0]; end
            endcase
            2'd2: begin
                path = "FT";
                if (!sub[3]) taken = sreg_m[sub[2:1]] ? !sub[0] : sub[0];
                else if (sub == 4'h8) taken = 1'b1;
                else if (sub == 4'h9) begin
                    taken = 1'b1;
                    if (ras_m.size() == 4) begin
                        fault_m[0] = 1'b1;
                        void'(ras_m.pop_front());
                    end
                    ras_m.push_back(pc_m + 8'd1);
                end else if (sub == 4'hA) begin
                    if (ras_m.size() == 0) fault_m[1] = 1'b1;
                    else begin
                        taken = 1'b1;
                        tgt = ras_m.pop_back();
                    end
                end
            end
            default: path = "FMLST";
        endcase
        for (int k = 0; k < path.len(); k++) begin
            byte s;
            s = path[k];
            bus.instr      = k == 0 ? ins : 16'($urandom);
            bus.pc_cur     = k == 0 ? pc_m : 8'($urandom);
            bus.reg_a_data = 8'($urandom);
            bus.reg_b_data = rb;
            bus.alu_sreg   = sr;
            @(negedge clk);
            check("strobes", 32'(strb()), 32'({!(s == "T" && !taken), s == "T" && taken,
                  s == "R", s == "W" && !cmp, s == "M", s == "S"}));
            if (s == "R") begin
                check("reg_a", 32'(bus.reg_a), 32'(ea));
                check("reg_b", 32'(bus.reg_b), 32'(eb));
            end
            if (s == "E") check("alu_fsl", 32'(bus.alu_fsl), 32'(sub));
            if (s == "W") begin
                check("reg_c", 32'(bus.reg_c), 32'(ec));
                check("wb_sel", 32'(bus.wb_sel), 32'(ewb));
                if (cls == 2'd1 && ls == 2'd0) check("imm", 32'(bus.imm), 32'(eimm));
            end
            if (s == "M") check("rd_addr", 32'(bus.mem_addr), 32'(ma_rd));
            if (s == "S") begin
                check("wr_addr", 32'(bus.mem_addr), 32'(ma_wr));
                check("mem_wsel", 32'(bus.mem_wsel), 32'(cls == 2'd3));
            end
            if (s == "T") begin
                if (taken) check("pc_target", 32'(bus.pc_target), 32'(tgt));
                check("sreg", 32'(bus.sreg), 32'(sreg_m));
                check("fault", 32'(bus.fault), 32'(fault_m));
                check("halted", 32'(bus.halted), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        pc_m = taken ? tgt : pc_m + 8'd1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ins;
        bus.instr = 16'd0; bus.pc_cur = 8'd0; bus.alu_sreg = 4'd0;
        bus.reg_a_data = 8'd0; bus.reg_b_data = 8'd0;
        pc_m = 8'h40;
        do_reset();
        run_instr(16'h00A6, 8'd5, 4'h3);
        run_instr(16'h3CA6, 8'd5, 4'h1);
        run_instr(16'h6110, 8'h12, 4'h0);
        run_instr(16'h8080, 8'd0, 4'h0);
        run_instr(16'h8480, 8'd0, 4'h0);
        run_instr(16'h4A55, 8'd0, 4'h0);
        run_instr(16'h53A0, 8'd0, 4'h0);
        run_instr(16'h7B3D, 8'd0, 4'h0);
        run_instr(16'hD2A9, 8'd0, 4'h0);
        bus.instr = 16'h00A6; bus.pc_cur = pc_m; bus.alu_sreg = 4'hF;
        repeat (3) begin
            @(posedge clk);
            #1 bus.instr = 16'($urandom);
        end
        @(negedge clk);
        check("wb_reached", 32'(bus.wr_en), 32'd1);
        do_reset();
        run_instr(16'h7B3D, 8'd0, 4'h0);
        for (int i = 0; i < 5; i++) run_instr(16'hA400 | 16'((16 + i) * 4), 8'd0, 4'h0);
        check("ras_overflow", 32'(bus.fault), 32'd1);
        for (int i = 0; i < 5; i++) run_instr(16'hA800, 8'd0, 4'h0);
        check("ras_underflow", 32'(bus.fault), 32'd3);
        bus.instr = 16'hBC00; bus.pc_cur = pc_m;
        @(negedge clk);
        check("halt_fetch", 32'(strb()), 32'h20);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1 bus.instr = 16'($urandom);
            @(negedge clk);
            check("halted_hold", 32'({bus.halted, strb()}), 32'h60);
        end
        do_reset();
        for (int i = 0; i < 300; i++) begin
            ins = 16'($urandom);
            if (ins[15:10] == 6'b101111) ins[10] = 1'b0;
            run_instr(ins, 8'($urandom), 4'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
